pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Program counter and instruction-fetch stage for the multicycle core; sits directly upstream of the control state machine.
//  Holds the PC and drives the fetch address/request to instruction memory.
//  Latches the returned word into the instruction register, which feeds the control FSM.
//  Applies the PC-update code pcEn issued by the FSM: increment, register jump, or PC-relative branch.
//  Also produces the link address for JAL.
// PARAMETERS
//  ADDR_W    16  PC / memory address width
//  RESET_PC  0   PC value loaded on reset
//  DISP_W    8   branch displacement width, taken from instruction[DISP_W-1:0]
// PORTS
//  clk          in   1       core clock; all state updates on rising edge
//  reset        in   1       synchronous, active-high reset
//  pcRegEn      in   1       fetch request from control FSM (asserted in FETCH)
//  pcEn         in   2       PC update: 00 hold, 01 pc+1, 10 jump, 11 branch
//  jump_target  in   ADDR_W  register-file value used for pcEn=10 (Jcond/JAL target)
//  mem_rdata    in   16      instruction word from memory
//  mem_valid    in   1       mem_rdata valid this cycle
//  mem_addr     out  ADDR_W  fetch address; always equals pc
//  mem_req      out  1       fetch request to memory
//  pc           out  ADDR_W  current program counter
//  link_addr    out  ADDR_W  pc+1 (mod 2^ADDR_W), combinational; written to link register by JAL
//  instruction  out  16      instruction register
//  ir_valid     out  1       instruction holds a fetched word since reset
//  stall        out  1       fetch outstanding; control FSM must hold in FETCH
// BEHAVIOUR
//  Reset (reset=1 at edge), overriding everything else:
//   - pc=RESET_PC, instruction=0, ir_valid=0, state=IDLE.
//   - Outputs: stall=0, mem_req=0.
//  FSM: two states, IDLE and WAIT.
//   - IDLE, pcRegEn=1, mem_valid=1: instruction<=mem_rdata and ir_valid<=1 at this edge (0-wait fetch); stay IDLE.
//   - IDLE, pcRegEn=1, mem_valid=0: go to WAIT.
//   - WAIT, mem_valid=1: instruction<=mem_rdata, ir_valid<=1, go to IDLE.
//   - WAIT, mem_valid=0: stay in WAIT.
//   - WAIT ignores pcRegEn.
//  mem_req = (IDLE & pcRegEn) | WAIT.
//  stall = mem_req & ~mem_valid (combinational).
//  PC update at each edge while state=IDLE and stall=0:
//   - 00: hold.
//   - 01: pc <= pc+1.
//   - 10: pc <= jump_target.
//   - 11: pc <= pc + sext(instruction[DISP_W-1:0]), where sext is the sign extension of the displacement to ADDR_W.
//   - Branch uses the IR contents as latched before this edge.
//  In WAIT, or while stall=1, pcEn is ignored and pc holds.
//  Arithmetic is modulo 2^ADDR_W:
//   - 0xFFFF+1 -> 0x0000.
//   - 0x0000 + sext(0xFF) -> 0xFFFF.
//  Simultaneous pcRegEn=1 & pcEn!=00 & mem_valid=1 in IDLE: the word is fetched from the old pc, and pc updates in the same edge.
//  Reset during WAIT: the outstanding fetch is abandoned and mem_valid is ignored in the reset cycle; the next cycle is IDLE.
//  instruction changes only on a fetch completion or on reset.
// TESTING
//  1. Reset then 0-wait fetch: pcRegEn=1, mem_valid=1, rdata=0x5123 -> instruction=0x5123, ir_valid=1, pc=0.
//  2. Increment and wrap: pc=0xFFFE, pcEn=01 for two cycles -> pc=0xFFFF, then 0x0000; link_addr=0x0000 at pc=0xFFFF.
//  3. Branch: IR=0xC0FC, pc=0x0010, pcEn=11 -> pc=0x000C; IR=0xC005, pc=0x0010 -> pc=0x0015.
//  4. Jump: jump_target=0x1234, pcEn=10 -> pc=0x1234; during the cycle before, link_addr=pc+1.
//  5. Wait states: pcRegEn=1 with mem_valid low for 3 cycles then high, pcEn=01 held ->
//     - stall=1 for 3 cycles;
//     - pc unchanged until completion;
//     - IR loads on the 4th edge.
//  6. Reset mid-WAIT: reset=1 with mem_valid=1 in the same cycle -> instruction=0, ir_valid=0, pc=RESET_PC, stall=0.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Program counter and instruction-fetch stage feeding the multicycle control FSM.
// Latency: a 0-wait fetch loads the IR at the requesting edge; each wait cycle adds one edge.
// Backpressure: stall is raised while a fetch is outstanding; pcEn is ignored until the fetch completes.
//
// Ports:
//   clk, reset   core clock; synchronous active-high reset
//   pcRegEn      fetch request from the control FSM
//   pcEn         PC update code: 00 hold, 01 pc+1, 10 jump, 11 branch
//   jump_target  register value used as the jump target
//   mem_rdata    instruction word returned by memory
//   mem_valid    mem_rdata is valid this cycle
//   mem_addr     fetch address (always pc)
//   mem_req      fetch request to memory
//   pc           current program counter
//   link_addr    pc+1, used as the JAL link value
//   instruction  instruction register
//   ir_valid     IR holds a fetched word since reset
//   stall        fetch outstanding; control FSM holds in FETCH
module pc_fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 DISP_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pcRegEn,
  input  logic [1:0]        pcEn,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic [15:0]       mem_rdata,
  input  logic              mem_valid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic [15:0]       instruction,
  output logic              ir_valid,
  output logic              stall
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] disp_sext;
  logic [ADDR_W-1:0] pc_branch;
  logic              fetch_done;
  logic              pc_upd;

  // Wrap-around arithmetic falls out of the ADDR_W-wide sums.
  assign pc_plus1   = pc + ADDR_W'(1);
  assign disp_sext  = {{(ADDR_W-DISP_W){instruction[DISP_W-1]}}, instruction[DISP_W-1:0]};
  assign pc_branch  = pc + disp_sext;

  assign mem_req    = ((state == IDLE) && pcRegEn) || (state == WAIT);
  assign stall      = mem_req && !mem_valid;
  assign mem_addr   = pc;
  assign link_addr  = pc_plus1;

  // A fetch completes when memory answers a live request, either in the
  // requesting cycle (0-wait) or later from WAIT.
  assign fetch_done = mem_req && mem_valid;
  // PC only moves from IDLE with no fetch outstanding; the branch uses the
  // IR value from before this edge, so a same-edge fetch does not affect it.
  assign pc_upd     = (state == IDLE) && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instruction <= '0;
      ir_valid    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pcRegEn && !mem_valid) state <= WAIT;
        WAIT: if (mem_valid)             state <= IDLE;
        default:                         state <= IDLE;
      endcase

      if (fetch_done) begin
        instruction <= mem_rdata;
        ir_valid    <= 1'b1;
      end

      if (pc_upd) begin
        case (pcEn)
          2'b01:   pc <= pc_plus1;
          2'b10:   pc <= jump_target;
          2'b11:   pc <= pc_branch;
          default: pc <= pc;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pc_fetch_unit.sv
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcRegEn;
  logic [1:0]  pcEn;
  logic [15:0] jump_target;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic [15:0] pc;
  logic [15:0] link_addr;
  logic [15:0] instruction;
  logic        ir_valid;
  logic        stall;

  int n_cmp = 0;
  int n_bad = 0;

  pc_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .DISP_W(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .pcRegEn     (pcRegEn),
    .pcEn        (pcEn),
    .jump_target (jump_target),
    .mem_rdata   (mem_rdata),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_req     (mem_req),
    .pc          (pc),
    .link_addr   (link_addr),
    .instruction (instruction),
    .ir_valid    (ir_valid),
    .stall       (stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rq, input logic [1:0] en, input logic [15:0] jt,
                       input logic vld, input logic [15:0] rd);
    pcRegEn     = rq;
    pcEn        = en;
    jump_target = jt;
    mem_valid   = vld;
    mem_rdata   = rd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000);
    step();
    step();
    chk("rst_pc",       pc,                   16'h0000);
    chk("rst_ir",       instruction,          16'h0000);
    chk("rst_irv",      {15'd0, ir_valid},    16'h0000);
    chk("rst_stall",    {15'd0, stall},       16'h0000);
    chk("rst_req",      {15'd0, mem_req},     16'h0000);
    reset = 1'b0;

    // 1. 0-wait fetch
    drive(1'b1, 2'b00, 16'h0000, 1'b1, 16'h5123);
    #1;
    chk("f0_req",       {15'd0, mem_req},     16'h0001);
    chk("f0_stall",     {15'd0, stall},       16'h0000);
    chk("f0_addr",      mem_addr,             16'h0000);
    step();
    chk("f0_ir",        instruction,          16'h5123);
    chk("f0_irv",       {15'd0, ir_valid},    16'h0001);
    chk("f0_pc",        pc,                   16'h0000);

    // 2. increment and wrap
    drive(1'b0, 2'b10, 16'hFFFE, 1'b0, 16'h0000);
    step();
    chk("j_fffe",       pc,                   16'hFFFE);
    drive(1'b0, 2'b01, 16'h0000, 1'b0, 16'h0000);
    step();
    chk("inc_ffff",     pc,                   16'hFFFF);
    chk("link_wrap",    link_addr,            16'h0000);
    step();
    chk("inc_wrap",     pc,                   16'h0000);

    // 3. branch: fetch C0FC from pc=0 while jumping to 0x0010 in the same edge
    drive(1'b1, 2'b10, 16'h0010, 1'b1, 16'hC0FC);
    #1;
    chk("fj_addr",      mem_addr,             16'h0000);
    step();
    chk("fj_pc",        pc,                   16'h0010);
    chk("fj_ir",        instruction,          16'hC0FC);
    drive(1'b0, 2'b11, 16'h0000, 1'b0, 16'h0000);
    step();
    chk("br_neg",       pc,                   16'h000C);
    drive(1'b1, 2'b10, 16'h0010, 1'b1, 16'hC005);
    step();
    chk("fj2_ir",       instruction,          16'hC005);
    drive(1'b0, 2'b11, 16'h0000, 1'b0, 16'h0000);
    step();
    chk("br_pos",       pc,                   16'h0015);
    // branch wrap: 0x0000 + sext(0xFF) = 0xFFFF
    drive(1'b1, 2'b10, 16'h0000, 1'b1, 16'h00FF);
    step();
    drive(1'b0, 2'b11, 16'h0000, 1'b0, 16'h0000);
    step();
    chk("br_wrap",      pc,                   16'hFFFF);

    // 4. jump with link address
    drive(1'b0, 2'b10, 16'h1234, 1'b0, 16'h0000);
    #1;
    chk("jal_link",     link_addr,            16'h0000);
    step();
    chk("jmp_pc",       pc,                   16'h1234);
    chk("jmp_link",     link_addr,            16'h1235);

    // 5. three wait states with pcEn=01 held
    drive(1'b1, 2'b01, 16'h0000, 1'b0, 16'hA5A5);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("ws_stall%0d", i), {15'd0, stall}, 16'h0001);
      step();
      chk($sformatf("ws_pc%0d", i),    pc,             16'h1234);
      chk($sformatf("ws_ir%0d", i),    instruction,    16'h00FF);
    end
    mem_valid = 1'b1;
    #1;
    chk("ws_done_stall", {15'd0, stall},      16'h0000);
    step();
    chk("ws_ir",        instruction,          16'hA5A5);
    chk("ws_pc_hold",   pc,                   16'h1234);
    drive(1'b0, 2'b01, 16'h0000, 1'b0, 16'h0000);
    step();
    chk("ws_pc_inc",    pc,                   16'h1235);

    // 6. reset in the middle of WAIT with mem_valid high
    drive(1'b1, 2'b00, 16'h0000, 1'b0, 16'h0000);
    step();
    chk("mw_stall",     {15'd0, stall},       16'h0001);
    reset = 1'b1;
    drive(1'b0, 2'b01, 16'h0000, 1'b1, 16'hBEEF);
    step();
    reset = 1'b0;
    drive(1'b0, 2'b00, 16'h0000, 1'b0, 16'h0000);
    #1;
    chk("mw_ir",        instruction,          16'h0000);
    chk("mw_irv",       {15'd0, ir_valid},    16'h0000);
    chk("mw_pc",        pc,                   16'h0000);
    chk("mw_stall0",    {15'd0, stall},       16'h0000);
    chk("mw_req0",      {15'd0, mem_req},     16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
